// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic/shift ops, Booth multiply, optional restoring divide.
// Define MULTICYCLE_ALU_DIV_EN to build the divider and its DIV state; otherwise DIV decodes as illegal.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] Zhigh,
    output logic [WIDTH-1:0] Zlow
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MULTICYCLE_ALU_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        zh_q, zh_d, zl_q, zl_d;
    logic                    err_q, err_d;

    logic [SW-1:0]           amt;
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ill;

    logic signed [WIDTH:0]   mcand_q, acc_q, acc_sum, acc_nx;
    logic [WIDTH-1:0]        mq_q, mq_nx;
    logic                    q1_q;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input logic [SW-1:0] n);
        logic [2*WIDTH-1:0] t;
        t = {v, v} << n;
        return t[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [SW-1:0] n);
        logic [2*WIDTH-1:0] t;
        t = {v, v} >> n;
        return t[WIDTH-1:0];
    endfunction

    assign amt = B[SW-1:0];
    assign a_s = A;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (opcode)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ROL:  alu_res = rotl(A, amt);
            OP_ROR:  alu_res = rotr(A, amt);
            OP_SHR:  alu_res = A >> amt;
            OP_SHRA: alu_res = a_s >>> amt;
            OP_SHL:  alu_res = A << amt;
            OP_NEG:  alu_res = -B;
            OP_NOT:  alu_res = ~B;
            default: alu_ill = 1'b1;
        endcase
    end

    // Booth step: add/subtract on the {Q[0], q-1} pair, then arithmetic shift of {acc, Q}.
    always_comb begin
        case ({mq_q[0], q1_q})
            2'b01:   acc_sum = acc_q + mcand_q;
            2'b10:   acc_sum = acc_q - mcand_q;
            default: acc_sum = acc_q;
        endcase
        acc_nx = acc_sum >>> 1;
        mq_nx  = {acc_sum[0], mq_q[WIDTH-1:1]};
    end

`ifdef MULTICYCLE_ALU_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_nx, quo_q, quo_nx, dvs_q;
    logic [WIDTH:0]   rem_sh, rem_trial;
    logic             qneg_q, rneg_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Unsigned restoring step on magnitudes; signs are reapplied on completion.
    always_comb begin
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        rem_trial = rem_sh - {1'b0, dvs_q};
        rem_nx    = rem_trial[WIDTH] ? rem_sh[WIDTH-1:0] : rem_trial[WIDTH-1:0];
        quo_nx    = {quo_q[WIDTH-2:0], ~rem_trial[WIDTH]};
    end

    always_ff @(posedge clock) begin
        if (state_q == IDLE) begin
            rem_q  <= '0;
            quo_q  <= mag(A);
            dvs_q  <= mag(B);
            qneg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            rneg_q <= A[WIDTH-1];
        end else if (state_q == DIV) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (state_q == IDLE) begin
            mcand_q <= {A[WIDTH-1], A};
            acc_q   <= '0;
            mq_q    <= B;
            q1_q    <= 1'b0;
        end else if (state_q == MUL) begin
            acc_q <= acc_nx;
            mq_q  <= mq_nx;
            q1_q  <= mq_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zh_d    = zh_q;
        zl_d    = zl_q;
        err_d   = err_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    case (opcode)
                        OP_MUL: state_d = MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
                        OP_DIV: begin
                            if (B == '0) begin
                                state_d = DONE;
                                zh_d    = A;
                                zl_d    = '1;
                                err_d   = 1'b1;
                            end else begin
                                state_d = DIV;
                            end
                        end
`endif
                        default: begin
                            state_d = DONE;
                            zh_d    = '0;
                            zl_d    = alu_res;
                            err_d   = alu_ill;
                        end
                    endcase
                end
            end
            MUL: begin
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d = DONE;
                    zh_d    = acc_nx[WIDTH-1:0];
                    zl_d    = mq_nx;
                    err_d   = 1'b0;
                end
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            DIV: begin
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d = DONE;
                    zl_d    = qneg_q ? -quo_nx : quo_nx;
                    zh_d    = rneg_q ? -rem_nx : rem_nx;
                    err_d   = 1'b0;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zh_q    <= '0;
            zl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zh_q    <= zh_d;
            zl_q    <= zl_d;
            err_q   <= err_d;
        end
    end

    assign Zhigh = zh_q;
    assign Zlow  = zl_q;
    assign err   = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=32; DIV cases follow MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;
    localparam int W = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic [4:0]   opcode;
    logic [W-1:0] A, B;
    logic         busy, done, err;
    logic [W-1:0] Zhigh, Zlow;

    int total = 0;
    int bad   = 0;

    multicycle_alu #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .opcode(opcode),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .Zhigh (Zhigh),
        .Zlow  (Zlow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one start and count cycles until done (bounded).
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        start = 1'b1; opcode = op; A = a; B = b;
        tick();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b1; opcode = OP_ADD; A = 32'd1; B = 32'd2;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (Zhigh !== 32'h0) begin bad++; $display("FAIL reset_zhigh: got %h want 0", Zhigh); end
        total++; if (Zlow !== 32'h0) begin bad++; $display("FAIL reset_zlow: got %h want 0", Zlow); end
        clear = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [4:0]   v_op [15];
        logic [W-1:0] v_a [15];
        logic [W-1:0] v_b [15];
        logic [W-1:0] v_z [15];
        int lat;
        v_op = '{OP_ADD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROL, OP_ROR, OP_SHR,
                 OP_SHRA, OP_SHRA, OP_SHL, OP_SHL, OP_NEG, OP_NOT, OP_ROR};
        v_a  = '{32'd3, 32'hFFFFFFFF, 32'd5, 32'hF0F0FFFF, 32'hF0000000, 32'h80000001,
                 32'h00000018, 32'h80000000, 32'h80000000, 32'h40000000, 32'h1,
                 32'h1234, 32'h99, 32'h77, 32'h12345678};
        v_b  = '{32'd4, 32'd2, 32'd7, 32'h0FF00F0F, 32'h0000000F, 32'h24, 32'd4,
                 32'd4, 32'd4, 32'hFFFFFFE4, 32'h21, 32'h20, 32'd5, 32'h0F0F0F0F, 32'h0};
        v_z  = '{32'd7, 32'd1, 32'hFFFFFFFE, 32'h00F00F0F, 32'hF000000F, 32'h00000018,
                 32'h80000001, 32'h08000000, 32'hF8000000, 32'h04000000, 32'h2,
                 32'h1234, 32'hFFFFFFFB, 32'hF0F0F0F0, 32'h12345678};
        for (int i = 0; i < 15; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], lat);
            total++; if (lat !== 1) begin bad++; $display("FAIL single%0d_latency: got %0d want 1", i, lat); end
            total++; if (Zlow !== v_z[i]) begin bad++; $display("FAIL single%0d_zlow: got %h want %h", i, Zlow, v_z[i]); end
            total++; if (Zhigh !== 32'h0) begin bad++; $display("FAIL single%0d_zhigh: got %h want 0", i, Zhigh); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL single%0d_err: got %b want 0", i, err); end
            tick();
            total++; if (busy !== 1'b0 || done !== 1'b0) begin
                bad++; $display("FAIL single%0d_idle: got busy=%b done=%b want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] v_a [3];
        logic [W-1:0] v_b [3];
        logic [W-1:0] v_h [3];
        logic [W-1:0] v_l [3];
        int lat;
        v_a = '{32'hFFFFFFF9, 32'h80000000, 32'h7FFFFFFF};
        v_b = '{32'd6,        32'h80000000, 32'h7FFFFFFF};
        v_h = '{32'hFFFFFFFF, 32'h40000000, 32'h3FFFFFFF};
        v_l = '{32'hFFFFFFD6, 32'h00000000, 32'h00000001};
        for (int i = 0; i < 3; i++) begin
            run_op(OP_MUL, v_a[i], v_b[i], lat);
            total++; if (lat !== 33) begin bad++; $display("FAIL mul%0d_latency: got %0d want 33", i, lat); end
            total++; if (Zhigh !== v_h[i]) begin bad++; $display("FAIL mul%0d_zhigh: got %h want %h", i, Zhigh, v_h[i]); end
            total++; if (Zlow !== v_l[i]) begin bad++; $display("FAIL mul%0d_zlow: got %h want %h", i, Zlow, v_l[i]); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL mul%0d_err: got %b want 0", i, err); end
            tick();
        end
    endtask

    task automatic test_div();
        int lat;
`ifdef MULTICYCLE_ALU_DIV_EN
        logic [W-1:0] v_a [4];
        logic [W-1:0] v_b [4];
        logic [W-1:0] v_h [4];
        logic [W-1:0] v_l [4];
        int           v_t [4];
        logic         v_e [4];
        v_a = '{32'hFFFFFFEF, 32'd100, 32'h80000000, 32'd100};
        v_b = '{32'd5,        32'd0,   32'hFFFFFFFF, 32'd7};
        v_l = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd14};
        v_h = '{32'hFFFFFFFE, 32'h00000064, 32'h0, 32'd2};
        v_t = '{33, 1, 33, 33};
        v_e = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_op(OP_DIV, v_a[i], v_b[i], lat);
            total++; if (lat !== v_t[i]) begin bad++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, v_t[i]); end
            total++; if (Zlow !== v_l[i]) begin bad++; $display("FAIL div%0d_zlow: got %h want %h", i, Zlow, v_l[i]); end
            total++; if (Zhigh !== v_h[i]) begin bad++; $display("FAIL div%0d_zhigh: got %h want %h", i, Zhigh, v_h[i]); end
            total++; if (err !== v_e[i]) begin bad++; $display("FAIL div%0d_err: got %b want %b", i, err, v_e[i]); end
            tick();
        end
`else
        run_op(OP_DIV, 32'd10, 32'd2, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL nodiv_latency: got %0d want 1", lat); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL nodiv_err: got %b want 1", err); end
        total++; if (Zlow !== 32'h0) begin bad++; $display("FAIL nodiv_zlow: got %h want 0", Zlow); end
        total++; if (Zhigh !== 32'h0) begin bad++; $display("FAIL nodiv_zhigh: got %h want 0", Zhigh); end
        tick();
`endif
    endtask

    task automatic test_illegal();
        int lat;
        run_op(OP_ADD, 32'h12345678, 32'h11111111, lat);
        tick();
        run_op(5'b11111, 32'h5, 32'h6, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL illegal_latency: got %0d want 1", lat); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b want 1", err); end
        total++; if (Zlow !== 32'h0) begin bad++; $display("FAIL illegal_zlow: got %h want 0", Zlow); end
        total++; if (Zhigh !== 32'h0) begin bad++; $display("FAIL illegal_zhigh: got %h want 0", Zhigh); end
        tick();
        run_op(5'b00000, 32'h5, 32'h6, lat);
        total++; if (lat !== 1 || err !== 1'b1) begin
            bad++; $display("FAIL illegal0: got lat=%0d err=%b want 1 1", lat, err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(OP_ADD, 32'd3, 32'd4, lat);
        total++; if (Zlow !== 32'd7 || lat !== 1) begin
            bad++; $display("FAIL b2b_first: got zlow=%h lat=%0d want 7 1", Zlow, lat);
        end
        start = 1'b1; opcode = OP_ADD; A = 32'd10; B = 32'd20;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_start_on_done: got busy=%b done=%b want 0 0", busy, done);
        end
        total++; if (Zlow !== 32'd7) begin bad++; $display("FAIL b2b_hold: got %h want 7", Zlow); end
        tick();
        start = 1'b0;
        total++; if (done !== 1'b1 || Zlow !== 32'd30) begin
            bad++; $display("FAIL b2b_second: got done=%b zlow=%h want 1 1e", done, Zlow);
        end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        start = 1'b1; opcode = OP_MUL; A = 32'd5; B = 32'd7;
        tick();
        start = 1'b0;
        repeat (4) begin tick(); if (done === 1'b1) seen++; end
        start = 1'b1; opcode = OP_ADD; A = 32'd1; B = 32'd1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL abort_ignore_start: got busy=%b done=%b want 1 0", busy, done);
        end
        repeat (4) begin tick(); if (done === 1'b1) seen++; end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (Zhigh !== 32'h0 || Zlow !== 32'h0) begin
            bad++; $display("FAIL abort_z: got %h_%h want 0_0", Zhigh, Zlow);
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", err); end
        repeat (40) begin tick(); if (done === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; opcode = '0; A = '0; B = '0;
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_illegal();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
